// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - HH:MM:SS timekeeping, RUN/SET mode machine, button debounce and blink
module clock_mode_ctrl #(
    parameter int TICKS_PER_SEC  = 100,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int BLINK_TICKS    = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       divclk,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_pulse
);

    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          divclk_q;
    logic          tick;
    logic [1:0]    btn_raw;
    logic [1:0]    btn_stable;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];
    logic          press_mode;
    logic          press_inc;
    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            divclk_q <= 1'b0;
        end else begin
            divclk_q <= divclk;
        end
    end

    assign tick = divclk & ~divclk_q;

    // Bit 0 is the mode button, bit 1 the increment button.
    assign btn_raw = {btn_inc, btn_mode};

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_stable <= '0;
            press      <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (tick) begin
                    if (btn_raw[i] != btn_stable[i]) begin
                        if (db_cnt[i] == DW'(DEBOUNCE_TICKS - 1)) begin
                            btn_stable[i] <= btn_raw[i];
                            db_cnt[i]     <= '0;
                            press[i]      <= btn_raw[i];
                        end else begin
                            db_cnt[i] <= db_cnt[i] + DW'(1);
                        end
                    end else begin
                        db_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // A mode change swallows an increment landing in the same cycle.
    assign press_mode = press[0];
    assign press_inc  = press[1] & ~press[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (press_mode) begin
            case (state)
                RUN:     state_next = SET_HR;
                SET_HR:  state_next = SET_MIN;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        mode = state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hours     <= '0;
            minutes   <= '0;
            seconds   <= '0;
            prescaler <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (tick) begin
                        if (prescaler == PW'(TICKS_PER_SEC - 1)) begin
                            prescaler <= '0;
                            sec_pulse <= 1'b1;
                            if (seconds == 6'd59) begin
                                seconds <= '0;
                                if (minutes == 6'd59) begin
                                    minutes <= '0;
                                    hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                                end else begin
                                    minutes <= minutes + 6'd1;
                                end
                            end else begin
                                seconds <= seconds + 6'd1;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                end
                SET_HR: begin
                    prescaler <= '0;
                    seconds   <= '0;
                    if (press_inc) begin
                        hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                    end
                end
                SET_MIN: begin
                    prescaler <= '0;
                    seconds   <= '0;
                    if (press_inc) begin
                        minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                    end
                end
                default: ;
            endcase
            // Any mode change restarts the second from zero, even alongside a RUN carry.
            if (press_mode) begin
                prescaler <= '0;
                seconds   <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (press_mode || state == RUN) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed and random checks of clock_mode_ctrl against a time-of-day model
module tb_clock_mode_ctrl;

    localparam int TPS = 4;
    localparam int DEB = 2;
    localparam int BLK = 3;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       divclk   = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    int tests  = 0;
    int fails  = 0;
    int cyc_n  = 0;
    int phase  = 0;
    int pulses = 0;

    clock_mode_ctrl #(
        .TICKS_PER_SEC (TPS),
        .DEBOUNCE_TICKS(DEB),
        .BLINK_TICKS   (BLK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .divclk   (divclk),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .mode     (mode),
        .blink    (blink),
        .sec_pulse(sec_pulse)
    );

    always #5 clock = ~clock;

    // Divider square wave: 8 clocks per period, high for the second half.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            phase  = (phase + 1) % 8;
            divclk = (phase >= 4);
        end
    end

    // Model state: time of day in seconds, mode as 0/1/2, ticks since entering a SET state.
    int m_tod = 0;
    int m_mode = 0;
    int m_bcnt = 0;
    int m_pre = 0;
    int m_pulse = 0;
    int m_prev_div = 0;
    int m_stable [2] = '{0, 0};
    int m_cnt    [2] = '{0, 0};
    int m_press  [2] = '{0, 0};

    task automatic model_step();
        int tick;
        int nm;
        int h;
        int mi;
        int btn [2];
        int np  [2];
        if (reset) begin
            m_tod = 0; m_mode = 0; m_bcnt = 0; m_pre = 0; m_pulse = 0; m_prev_div = 0;
            m_stable = '{0, 0}; m_cnt = '{0, 0}; m_press = '{0, 0};
        end else begin
            tick   = (divclk && m_prev_div == 0) ? 1 : 0;
            btn[0] = int'(btn_mode);
            btn[1] = int'(btn_inc);
            np     = '{0, 0};
            if (tick != 0) begin
                for (int b = 0; b < 2; b++) begin
                    if (btn[b] != m_stable[b]) begin
                        m_cnt[b]++;
                        if (m_cnt[b] == DEB) begin
                            m_stable[b] = btn[b];
                            m_cnt[b]    = 0;
                            np[b]       = btn[b];
                        end
                    end else begin
                        m_cnt[b] = 0;
                    end
                end
            end
            m_pulse = 0;
            nm = (m_press[0] != 0) ? (m_mode + 1) % 3 : m_mode;
            if (m_mode == 0) begin
                if (tick != 0) begin
                    m_pre++;
                    if (m_pre == TPS) begin
                        m_pre   = 0;
                        m_pulse = 1;
                        m_tod   = (m_tod + 1) % 86400;
                    end
                end
            end else begin
                if (m_press[1] != 0 && m_press[0] == 0) begin
                    h  = m_tod / 3600;
                    mi = (m_tod / 60) % 60;
                    if (m_mode == 1) h = (h + 1) % 24;
                    else             mi = (mi + 1) % 60;
                    m_tod = h * 3600 + mi * 60;
                end
                if (tick != 0) m_bcnt++;
            end
            if (nm != m_mode) begin
                m_pre  = 0;
                m_tod  = m_tod - (m_tod % 60);
                m_bcnt = 0;
            end
            if (nm == 0) m_bcnt = 0;
            m_mode     = nm;
            m_press    = np;
            m_prev_div = divclk ? 1 : 0;
        end
    endtask

    // Model advanced on every rising edge, DUT compared on the following falling edge.
    initial begin
        int eh, em, es, eb;
        forever begin
            @(posedge clock);
            model_step();
            @(negedge clock);
            cyc_n++;
            if (sec_pulse === 1'b1) pulses++;
            eh = m_tod / 3600;
            em = (m_tod / 60) % 60;
            es = m_tod % 60;
            eb = (m_mode == 0) ? 1 : (((m_bcnt / BLK) % 2 == 0) ? 1 : 0);
            tests++;
            if (hours !== 5'(eh) || minutes !== 6'(em) || seconds !== 6'(es) ||
                mode !== 2'(m_mode) || blink !== 1'(eb) || sec_pulse !== 1'(m_pulse)) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL cycle %0d model_cmp: got %0d:%0d:%0d mode=%0d blink=%0d pulse=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d pulse=%0d",
                             cyc_n, hours, minutes, seconds, mode, blink, sec_pulse,
                             eh, em, es, m_mode, eb, m_pulse);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        cyc();
        cyc();
        while (phase != 0) cyc();
        reset = 1'b0;
    endtask

    // Clean press: two high samples then two low samples.
    task automatic press_btn(input int which);
        if (which == 0) btn_mode = 1'b1; else btn_inc = 1'b1;
        run(16);
        btn_mode = 1'b0; btn_inc = 1'b0;
        run(16);
    endtask

    task automatic wait_pulse(input string name);
        int found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clock);
            if (sec_pulse === 1'b1) found = 1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_blink(output int at);
        logic prev;
        int   found = 0;
        at = 0;
        @(negedge clock);
        prev = blink;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clock);
            if (blink !== prev) begin
                found = 1;
                at    = cyc_n;
            end
        end
        check("blink_toggle_seen", found, 1);
    endtask

    initial begin
        int t1, t2, t3;

        do_reset();
        @(negedge clock);
        check("rst_hours", int'(hours), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_blink", int'(blink), 1);
        check("rst_pulse", int'(sec_pulse), 0);
        pulses = 0;
        run(33);
        @(negedge clock);
        check("first_second", int'(seconds), 1);
        check("first_pulse_count", pulses, 1);
        check("model_first_second", m_tod, 1);

        press_btn(0);
        check("enter_set_hr", int'(mode), 1);
        repeat (23) press_btn(1);
        press_btn(0);
        check("preload_hours", int'(hours), 23);
        check("enter_set_min", int'(mode), 2);
        repeat (59) press_btn(1);
        check("preload_minutes", int'(minutes), 59);
        press_btn(0);
        check("back_to_run", int'(mode), 0);
        check("run_seconds_zero", int'(seconds), 0);
        for (int k = 1; k <= 60; k++) begin
            wait_pulse("pulse_seen");
            if (k == 59) begin
                check("pre_wrap_h", int'(hours), 23);
                check("pre_wrap_m", int'(minutes), 59);
                check("pre_wrap_s", int'(seconds), 59);
            end
            if (k == 60) begin
                check("wrap_h", int'(hours), 0);
                check("wrap_m", int'(minutes), 0);
                check("wrap_s", int'(seconds), 0);
            end
        end

        btn_mode = 1'b1; run(8); btn_mode = 1'b0; run(32);
        check("glitch_ignored", int'(mode), 0);
        btn_mode = 1'b1; run(24); btn_mode = 1'b0; run(16);
        check("held_one_press", int'(mode), 1);

        repeat (25) press_btn(1);
        check("hours_25_presses", int'(hours), 1);
        press_btn(0);
        check("mode_set_min", int'(mode), 2);
        repeat (61) press_btn(1);
        check("minutes_61_presses", int'(minutes), 1);
        press_btn(0);
        check("mode_run_again", int'(mode), 0);
        check("seconds_cleared", int'(seconds), 0);

        press_btn(0);
        press_btn(0);
        check("set_min_for_both", int'(mode), 2);
        btn_mode = 1'b1; btn_inc = 1'b1; run(16);
        btn_mode = 1'b0; btn_inc = 1'b0; run(16);
        check("both_mode_wins", int'(mode), 0);
        check("both_minutes_kept", int'(minutes), 1);

        press_btn(0);
        wait_blink(t1);
        wait_blink(t2);
        wait_blink(t3);
        check("blink_period_a", t2 - t1, 24);
        check("blink_period_b", t3 - t2, 24);
        press_btn(0);
        press_btn(0);
        check("run_mode_blink", int'(blink), 1);

        press_btn(0);
        press_btn(0);
        run(5);
        btn_inc = 1'b1; run(8);
        reset = 1'b1; cyc();
        reset = 1'b0; btn_inc = 1'b0;
        @(negedge clock);
        check("midreset_hours", int'(hours), 0);
        check("midreset_minutes", int'(minutes), 0);
        check("midreset_mode", int'(mode), 0);
        check("midreset_blink", int'(blink), 1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 16 == 0) btn_mode = 1'($urandom % 2);
            if ($urandom % 16 == 0) btn_inc  = 1'($urandom % 2);
            reset = ($urandom % 700 == 0);
            cyc();
        end
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        run(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
